arq_gbn_tx: RTL and testbench

ARQ_GBN_TX -- requirements
Module: arq_gbn_tx

---
 rtl/arq_pkg.sv | 23 ++
 rtl/arq_timer.sv | 35 +++
 rtl/arq_gbn_tx.sv | 118 +++++++++++
 tb/tb_arq_gbn_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arq_pkg.sv
// Shared ARQ definitions: controller state encoding, default geometry and a
// counter-width helper used by the ARQ transmitters and their timer.
package arq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_FAIL = 2'd3
   } arq_state_e;

   localparam int unsigned ARQ_DW   = 10;
   localparam int unsigned ARQ_SW   = 3;
   localparam int unsigned ARQ_WIN  = 4;
   localparam int unsigned ARQ_TMO  = 64;
   localparam int unsigned ARQ_RMAX = 7;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned arq_cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arq_timer.sv
// Ack timeout counter: clear, load or count; expire marks the terminal count
// and the counter wraps to zero on it so the next period starts immediately.
module arq_timer
   import arq_pkg::*;
#(
   parameter int unsigned TMO = ARQ_TMO,
   parameter int unsigned TW  = arq_cnt_w(ARQ_TMO)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          en,
   output logic          expire
);

   logic [TW-1:0] cnt_q, cnt_d;

   assign expire = en && (cnt_q == TW'(TMO - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)         cnt_d = '0;
      else if (load)   cnt_d = load_val;
      else if (expire) cnt_d = '0;
      else if (en)     cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/arq_gbn_tx.sv
// Go-back-N ARQ transmitter: buffers payloads in a WIN-deep window, sends them
// in sequence order, retires them on cumulative acks and rewinds on timeout.
module arq_gbn_tx
   import arq_pkg::*;
#(
   parameter int unsigned DW   = ARQ_DW,
   parameter int unsigned SW   = ARQ_SW,
   parameter int unsigned WIN  = ARQ_WIN,
   parameter int unsigned TMO  = ARQ_TMO,
   parameter int unsigned RMAX = ARQ_RMAX
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 in_ready,
   output logic                 tx_valid,
   output logic [SW-1:0]        tx_seq,
   output logic [DW-1:0]        tx_data,
   input  logic                 tx_ready,
   input  logic                 ack_valid,
   input  logic [SW-1:0]        ack_seq,
   output logic [$clog2(WIN):0] outstanding,
   output logic                 retx,
   output logic                 fail
);

   localparam int unsigned IW = arq_cnt_w(WIN);
   localparam int unsigned TW = arq_cnt_w(TMO);
   localparam int unsigned RW = arq_cnt_w(RMAX + 1);
   localparam int unsigned OW = $clog2(WIN) + 1;

   arq_state_e    state_q, state_d;
   logic [SW-1:0] base_q, base_d, snd_q, snd_d, tail_q, tail_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          retx_q, retx_d;
   logic [DW-1:0] mem_q [WIN];

   logic [SW-1:0] occ, ack_off, inflight;
   logic          wr_en, tx_fire, ack_ok, tmo, give_up, rewind;
   logic          tmr_en, tmr_clr, tmr_expire;

   assign occ         = tail_q - base_q;
   assign outstanding = occ[OW-1:0];
   assign in_ready    = (state_q != ST_FAIL) && (occ < SW'(WIN));
   assign tx_valid    = (state_q == ST_SEND);
   assign tx_seq      = snd_q;
   assign tx_data     = tx_valid ? mem_q[snd_q[IW-1:0]] : '0;
   assign retx        = retx_q;
   assign fail        = (state_q == ST_FAIL);

   assign wr_en    = in_valid && in_ready;
   assign tx_fire  = tx_valid && tx_ready;
   assign ack_off  = ack_seq - base_q;
   assign inflight = snd_q - base_q;
   assign ack_ok   = ack_valid && !fail && (ack_off != '0) && (ack_off <= inflight);

   // An ack in the expiry cycle wins: it restarts the timer and cancels the rewind.
   assign tmo      = tmr_expire && !ack_ok;
   assign give_up  = tmo && (retry_q == RW'(RMAX));
   assign rewind   = tmo && !give_up;

   assign tmr_en   = (base_q != snd_q) && !fail;
   assign tmr_clr  = !tmr_en || ack_ok;

   arq_timer #(
      .TMO (TMO),
      .TW  (TW)
   ) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (tmr_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (tmr_en),
      .expire   (tmr_expire)
   );

   always_comb begin
      base_d  = ack_ok ? ack_seq : base_q;
      tail_d  = wr_en ? tail_q + SW'(1) : tail_q;
      snd_d   = snd_q;
      if (tx_fire) snd_d = snd_q + SW'(1);
      if (rewind)  snd_d = base_q;
      retry_d = retry_q;
      if (ack_ok)      retry_d = '0;
      else if (rewind) retry_d = retry_q + RW'(1);
      retx_d  = rewind;
      state_d = state_q;
      if (fail || give_up)     state_d = ST_FAIL;
      else if (base_d == tail_d) state_d = ST_IDLE;
      else if (snd_d != tail_d)  state_d = ST_SEND;
      else                       state_d = ST_WAIT;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         snd_q   <= '0;
         tail_q  <= '0;
         retry_q <= '0;
         retx_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         snd_q   <= snd_d;
         tail_q  <= tail_d;
         retry_q <= retry_d;
         retx_q  <= retx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[tail_q[IW-1:0]] <= in_data;
   end

endmodule

// File: tb/tb_arq_gbn_tx.sv
// Bench for arq_gbn_tx: directed scenarios plus random traffic, all compared
// against an unbounded-sequence reference model of the go-back-N rules.
module tb_arq_gbn_tx;

   localparam int DW   = 10;
   localparam int SW   = 3;
   localparam int WIN  = 4;
   localparam int TMO  = 64;
   localparam int RMAX = 7;
   localparam int MOD  = 1 << SW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          tx_ready = 1'b0;
   logic          ack_valid = 1'b0;
   logic [SW-1:0] ack_seq = '0;
   logic          in_ready, tx_valid, retx, fail;
   logic [SW-1:0] tx_seq;
   logic [DW-1:0] tx_data;
   logic [$clog2(WIN):0] outstanding;

   always #5 clk = ~clk;

   arq_gbn_tx #(
      .DW   (DW),
      .SW   (SW),
      .WIN  (WIN),
      .TMO  (TMO),
      .RMAX (RMAX)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .tx_valid    (tx_valid),
      .tx_seq      (tx_seq),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .ack_valid   (ack_valid),
      .ack_seq     (ack_seq),
      .outstanding (outstanding),
      .retx        (retx),
      .fail        (fail)
   );

   int n_chk = 0;
   int n_err = 0;
   int retx_seen = 0;

   // Reference model: absolute (non-wrapping) sequence numbers.
   int m_base = 0, m_snd = 0, m_tail = 0, m_tmr = 0, m_retry = 0;
   bit m_fail = 1'b0, m_retx = 1'b0;
   logic [DW-1:0] m_pay [int];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_in_ready", in_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_seq", tx_seq, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_retx", retx, 0);
      check("rst_fail", fail, 0);
   endtask

   // One clock: compare outputs mid-cycle, advance the model, step past the edge.
   task automatic tick();
      bit eir, etv, wr, tx, ack_ok, tmo;
      int d, n_tmr;
      @(negedge clk);
      eir = !m_fail && (m_tail - m_base) < WIN;
      etv = !m_fail && (m_snd != m_tail);
      check("in_ready", in_ready, eir);
      check("tx_valid", tx_valid, etv);
      check("tx_seq", tx_seq, m_snd % MOD);
      if (etv) check("tx_data", tx_data, m_pay[m_snd]);
      check("outstanding", outstanding, m_tail - m_base);
      check("retx", retx, m_retx);
      check("fail", fail, m_fail);
      if (retx) retx_seen++;
      if (!rstn) begin
         m_base = 0; m_snd = 0; m_tail = 0; m_tmr = 0; m_retry = 0;
         m_fail = 1'b0; m_retx = 1'b0;
      end else begin
         wr     = in_valid && eir;
         tx     = etv && tx_ready;
         d      = (int'(ack_seq) - m_base) & (MOD - 1);
         ack_ok = ack_valid && !m_fail && d >= 1 && d <= (m_snd - m_base);
         tmo    = !m_fail && (m_base != m_snd) && (m_tmr == TMO - 1) && !ack_ok;
         n_tmr  = (m_fail || ack_ok || m_base == m_snd || m_tmr == TMO - 1) ? 0 : m_tmr + 1;
         m_retx = 1'b0;
         if (wr) begin
            m_pay[m_tail] = in_data;
            m_tail++;
         end
         if (tx) m_snd++;
         if (ack_ok) begin
            m_base  = m_base + d;
            m_retry = 0;
         end else if (tmo) begin
            if (m_retry == RMAX) m_fail = 1'b1;
            else begin
               m_retry++;
               m_snd  = m_base;
               m_retx = 1'b1;
            end
         end
         m_tmr = n_tmr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = DW'($urandom);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic ack_rel(input int k);
      ack_valid = 1'b1;
      ack_seq   = SW'((m_base + k) % MOD);
      tick();
      ack_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      rstn = 1'b1;

      // In-order send of four frames, then cumulative ack of all.
      tx_ready = 1'b1;
      push(4);
      repeat (3) tick();
      ack_rel(4);
      tick();
      check("drain_outstanding", outstanding, 0);
      check("drain_tx_seq", tx_seq, 4);

      // Unacked window times out once and is replayed.
      retx_seen = 0;
      push(4);
      repeat (73) tick();
      check("retx_once", retx_seen, 1);
      check("retx_outstanding", outstanding, 4);
      ack_rel(4);
      tick();

      // Full window blocks input until a partial ack frees space.
      tx_ready = 1'b0;
      push(6);
      check("full_in_ready", in_ready, 0);
      tx_ready = 1'b1;
      repeat (5) tick();
      ack_rel(2);
      check("part_outstanding", outstanding, 2);
      check("part_in_ready", in_ready, 1);
      ack_rel(2);
      tick();

      // Out-of-range and duplicate acks leave state untouched.
      tx_ready = 1'b0;
      push(4);
      tx_ready = 1'b1;
      repeat (3) tick();
      tx_ready = 1'b0;
      ack_rel(5);
      ack_rel(0);
      check("stale_outstanding", outstanding, 4);
      check("stale_tx_seq", tx_seq, (m_base + 3) % MOD);

      // Ack lands in the expiry cycle: no rewind.
      for (int i = 0; i < 2 * TMO && m_tmr != TMO - 1; i++) tick();
      check("tmo_wait", m_tmr, TMO - 1);
      ack_rel(1);
      check("ack_tmo_retx", retx, 0);
      check("ack_tmo_tx_seq", tx_seq, (m_base + 2) % MOD);
      tick();
      tx_ready = 1'b1;
      repeat (4) tick();
      ack_rel(m_tail - m_base);
      tick();

      // Random traffic with wrap-around, stray acks and occasional reset.
      for (int i = 0; i < 1500; i++) begin
         rstn      = ($urandom_range(0, 199) != 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = DW'($urandom);
         tx_ready  = ($urandom_range(0, 9) < 7);
         ack_valid = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 7) == 0 || m_snd == m_base) ack_seq = SW'($urandom);
         else ack_seq = SW'((m_base + int'($urandom_range(1, m_snd - m_base))) % MOD);
         tick();
      end
      rstn = 1'b1; in_valid = 1'b0; ack_valid = 1'b0;

      // Retry exhaustion: seven rewinds then sticky failure.
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tx_ready = 1'b1;
      retx_seen = 0;
      push(4);
      for (int i = 0; i < 12 * TMO && !m_fail; i++) tick();
      check("fail_flag", fail, 1);
      check("fail_in_ready", in_ready, 0);
      check("fail_tx_valid", tx_valid, 0);
      check("fail_retx_count", retx_seen, RMAX);
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      rstn = 1'b0;
      tick();
      check_reset_vals();
      rstn = 1'b1;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
